// File: rtl/ad_pkg.sv
// Shared types and default timing for the serial ADC capture front end.
// Defaults assume a 50 MHz system clock and a TLC549-class converter.
package ad_pkg;

  localparam int AD_DATA_W       = 8;
  localparam int AD_HALF_CYCLES  = 25;
  localparam int AD_SETUP_CYCLES = 75;
  localparam int AD_CONV_CYCLES  = 850;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_CONV  = 2'd3
  } ad_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ad_sclk_gen.sv
// AD_CLK generator: 8 bits, each HALF_CYCLES low then HALF_CYCLES high.
// i_start launches a burst; o_done marks the last cycle of the 8th high phase.
module ad_sclk_gen
  import ad_pkg::*;
#(
  parameter int HALF_CYCLES = AD_HALF_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_sclk,
  output logic o_rise,
  output logic o_done
);

  localparam int                CW        = $clog2(HALF_CYCLES + 1);
  localparam logic [CW-1:0]     HALF_LAST = CW'(HALF_CYCLES - 1);

  logic          r_active;
  logic          r_phase;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_rise;
  logic          w_phase_end;

  assign w_phase_end = r_active && (r_cnt == HALF_LAST);
  assign o_done      = w_phase_end && r_phase && (r_bit_cnt == 3'd7);
  assign o_sclk      = r_sclk;
  assign o_rise      = r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_phase   <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (i_start) begin
        r_active  <= 1'b1;
        r_phase   <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_cnt     <= '0;
        r_sclk    <= 1'b0;
      end else if (r_active) begin
        if (!w_phase_end) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_cnt <= '0;
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_sclk  <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            // Bit counter parks at 7 once the burst ends; i_start rearms it.
            if (r_bit_cnt == 3'd7) r_active <= 1'b0;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ad_serial_capture.sv
// TLC549-style serial ADC front end: CS/clock sequencing, deserialisation,
// and a registered sample presented on the AD_CS rising edge.
module ad_serial_capture
  import ad_pkg::*;
#(
  parameter int HALF_CYCLES  = AD_HALF_CYCLES,
  parameter int SETUP_CYCLES = AD_SETUP_CYCLES,
  parameter int CONV_CYCLES  = AD_CONV_CYCLES
) (
  input  logic                 CLK_50M,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic                 AD_DOUT,
  output logic                 AD_CS,
  output logic                 AD_CLK,
  output logic [AD_DATA_W-1:0] out_ad_data,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int               CNT_W      = $clog2(max3(SETUP_CYCLES, HALF_CYCLES, CONV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);

  ad_state_e              r_state;
  ad_state_e              w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_din_s1;
  logic                   r_din_s2;
  logic [AD_DATA_W-1:0]   r_shreg;
  logic [AD_DATA_W-1:0]   r_data;
  logic                   r_valid;
  logic                   r_cs;
  logic                   r_busy;
  logic                   r_discard;
  logic                   w_start;
  logic                   w_sclk;
  logic                   w_rise;
  logic                   w_done;
  logic                   w_capture;
  logic [AD_DATA_W-1:0]   w_shreg_next;

  ad_sclk_gen #(.HALF_CYCLES(HALF_CYCLES)) u_sclk_gen (
    .clk     (CLK_50M),
    .rst_n   (RST_N),
    .i_start (w_start),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_done  (w_done)
  );

  // Forwarding the pending shift keeps the capture correct even when HALF_CYCLES=1.
  assign w_shreg_next = w_rise ? {r_shreg[AD_DATA_W-2:0], r_din_s2} : r_shreg;
  assign w_capture    = (r_state == S_SHIFT) && w_done;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE:  if (enable) w_next_state = S_SETUP;
      S_SETUP: if (r_cnt == SETUP_LAST) begin
                 w_next_state = S_SHIFT;
                 w_start      = 1'b1;
               end
      S_SHIFT: if (w_done) w_next_state = S_CONV;
      S_CONV:  if (r_cnt == CONV_LAST) w_next_state = enable ? S_SETUP : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_din_s1  <= 1'b0;
      r_din_s2  <= 1'b0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_discard <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_din_s1 <= AD_DOUT;
      r_din_s2 <= r_din_s1;

      if (r_state != w_next_state)                      r_cnt <= '0;
      else if (r_state == S_SETUP || r_state == S_CONV) r_cnt <= r_cnt + CNT_W'(1);

      if (w_rise) r_shreg <= w_shreg_next;

      // Outputs decode the next state so they line up with the state register.
      r_cs    <= (w_next_state == S_IDLE) || (w_next_state == S_CONV);
      r_busy  <= (w_next_state != S_IDLE);
      r_valid <= w_capture && !r_discard;
      if (w_capture && !r_discard) r_data <= w_shreg_next;

      // The converter returns the previous result, so the first frame after a restart is stale.
      if (w_capture && r_discard)                          r_discard <= 1'b0;
      else if (r_state == S_CONV && w_next_state == S_IDLE) r_discard <= 1'b1;
    end
  end

  assign AD_CS        = r_cs;
  assign AD_CLK       = w_sclk;
  assign out_ad_data  = r_data;
  assign sample_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ad_serial_capture.sv
// Directed bench for ad_serial_capture with a previous-result ADC model.
// Timing under test: HALF=2, SETUP=3, CONV=5 -> 40-cycle frame.
module tb_ad_serial_capture;

  logic       CLK_50M;
  logic       RST_N;
  logic       enable;
  logic       AD_DOUT;
  logic       AD_CS;
  logic       AD_CLK;
  logic [7:0] out_ad_data;
  logic       sample_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  ad_serial_capture #(
    .HALF_CYCLES  (2),
    .SETUP_CYCLES (3),
    .CONV_CYCLES  (5)
  ) dut (
    .CLK_50M      (CLK_50M),
    .RST_N        (RST_N),
    .enable       (enable),
    .AD_DOUT      (AD_DOUT),
    .AD_CS        (AD_CS),
    .AD_CLK       (AD_CLK),
    .out_ad_data  (out_ad_data),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    CLK_50M = 1'b0;
    forever #5 CLK_50M = ~CLK_50M;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before 600000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- ADC model ----------------
  // Shifts MSB on CS fall, next bit on each AD_CLK fall; latches a new
  // conversion on every CS rise, which is returned in the following frame.
  logic [7:0] analog_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] adc_conv = 8'h5A;
  logic [7:0] adc_shift = 8'h00;
  int         idx = 0;
  bit         model_on = 1'b0;

  initial begin
    logic pcs, pclk;
    AD_DOUT = 1'b0;
    pcs     = 1'b1;
    pclk    = 1'b0;
    forever begin
      @(AD_CS or AD_CLK);
      if (pcs === 1'b1 && AD_CS === 1'b0) begin
        idx       = 0;
        adc_shift = adc_conv;
        AD_DOUT   = adc_shift[7];
      end else if (pcs === 1'b0 && AD_CS === 1'b1 && model_on) begin
        if (analog_q.size() > 0) adc_conv = analog_q.pop_front();
        else                     adc_conv = 8'h00;
      end
      if (pclk === 1'b1 && AD_CLK === 1'b0 && AD_CS === 1'b0 && idx < 7) begin
        idx++;
        AD_DOUT = adc_shift[7-idx];
      end
      pcs  = AD_CS;
      pclk = AD_CLK;
    end
  end

  // ---------------- timing monitor ----------------
  int   cyc = 0, cs_fall_t = 0, cs_rise_t = 0, last_rise_t = 0;
  int   rises = 0, last_rises = 0, first_off = 0, period = 0;
  int   bad_interval = 0, sclk_hi_errs = 0, strobe_misalign = 0;
  int   data_change_errs = 0, valid_count = 0;
  logic m_prev_cs = 1'b1, m_prev_clk = 1'b0;
  logic [7:0] m_prev_data = 8'h00;

  initial begin
    bit cs_rise_now;
    forever begin
      @(negedge CLK_50M);
      cyc++;
      cs_rise_now = (m_prev_cs === 1'b0) && (AD_CS === 1'b1);
      if (m_prev_cs === 1'b1 && AD_CS === 1'b0) begin
        cs_fall_t = cyc;
        rises     = 0;
      end
      if (m_prev_clk === 1'b0 && AD_CLK === 1'b1) begin
        if (rises == 0)                first_off = cyc - cs_fall_t;
        else if (cyc - last_rise_t != 4) bad_interval++;
        last_rise_t = cyc;
        rises++;
      end
      if (cs_rise_now) begin
        last_rises = rises;
        period     = cyc - cs_rise_t;
        cs_rise_t  = cyc;
      end
      if (AD_CS === 1'b1 && AD_CLK !== 1'b0) sclk_hi_errs++;
      if (sample_valid === 1'b1) begin
        valid_count++;
        if (!cs_rise_now) strobe_misalign++;
      end
      if (out_ad_data !== m_prev_data && !cs_rise_now) data_change_errs++;
      m_prev_cs   = AD_CS;
      m_prev_clk  = AD_CLK;
      m_prev_data = out_ad_data;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for AD_CS (on_clk=0) or AD_CLK (on_clk=1) to move to to_level.
  task automatic wait_edge(input bit on_clk, input logic to_level, input string tag);
    logic prev, now;
    bit   ok;
    ok   = 1'b0;
    prev = on_clk ? AD_CLK : AD_CS;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_50M);
      now = on_clk ? AD_CLK : AD_CS;
      if (now === to_level && prev !== to_level) begin
        ok = 1'b1;
        break;
      end
      prev = now;
    end
    #1;
    check({tag, "_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic valid, input logic [7:0] data);
    wait_edge(1'b0, 1'b1, tag);
    check({tag, "_valid"}, {31'd0, sample_valid}, {31'd0, valid});
    check({tag, "_data"},  {24'd0, out_ad_data},  {24'd0, data});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int snap;
    logic [7:0] r;

    RST_N  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge CLK_50M);
    check("rst_cs",    {31'd0, AD_CS},        32'd1);
    check("rst_clk",   {31'd0, AD_CLK},       32'd0);
    check("rst_data",  {24'd0, out_ad_data},  32'h00);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},         32'd0);

    foreach (analog_q[i]) analog_q.delete(i);
    analog_q = '{8'hA5, 8'h3C, 8'h80, 8'h01, 8'hFF, 8'h66,
                 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
    RST_N    = 1'b1;
    model_on = 1'b1;
    @(negedge CLK_50M);
    enable = 1'b1;

    // First frame is stale; second returns the first conversion.
    expect_frame("f1_discard", 1'b0, 8'h00);
    check("f1_busy", {31'd0, busy}, 32'd1);
    expect_frame("f2_a5", 1'b1, 8'hA5);
    check("period_f2", period, 32'd40);
    expect_frame("f3_3c", 1'b1, 8'h3C);
    expect_frame("f4_80", 1'b1, 8'h80);
    expect_frame("f5_01", 1'b1, 8'h01);
    expect_frame("f6_ff", 1'b1, 8'hFF);
    check("first_rise_off", first_off,    32'd5);
    check("rises_per_frame", last_rises,  32'd8);
    check("rise_interval",  bad_interval, 32'd0);
    check("clk_while_cs_hi", sclk_hi_errs, 32'd0);

    // Drop enable mid-shift: frame completes, then idle; restart discards once.
    wait_edge(1'b1, 1'b1, "f7_shift");
    enable = 1'b0;
    expect_frame("f7_66", 1'b1, 8'h66);
    repeat (8) @(negedge CLK_50M);
    check("idle_busy", {31'd0, busy},       32'd0);
    check("idle_cs",   {31'd0, AD_CS},      32'd1);
    check("idle_data", {24'd0, out_ad_data}, 32'h66);
    enable = 1'b1;
    expect_frame("f8_discard", 1'b0, 8'h66);
    expect_frame("f9_22", 1'b1, 8'h22);

    // Enable blip inside S_CONV must not cause a discard.
    enable = 1'b0;
    repeat (2) @(negedge CLK_50M);
    enable = 1'b1;
    expect_frame("f10_33", 1'b1, 8'h33);

    // Asynchronous reset in the middle of a shift.
    wait_edge(1'b1, 1'b1, "f11_shift");
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_cs",    {31'd0, AD_CS},        32'd1);
    check("mid_rst_clk",   {31'd0, AD_CLK},       32'd0);
    check("mid_rst_data",  {24'd0, out_ad_data},  32'h00);
    check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},         32'd0);
    @(negedge CLK_50M);
    RST_N = 1'b1;
    expect_frame("f12_discard", 1'b0, 8'h00);
    wait_edge(1'b0, 1'b0, "f13_cs_fall");
    enable = 1'b0;
    expect_frame("f13_77", 1'b1, 8'h77);
    repeat (10) @(negedge CLK_50M);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("model_q_drained", analog_q.size(), 32'd0);

    // 100 back-to-back frames with random data.
    snap = valid_count;
    for (int i = 0; i < 99; i++) begin
      r = 8'($urandom_range(0, 255));
      analog_q.push_back(r);
      exp_q.push_back(r);
    end
    enable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 100) begin
        wait_edge(1'b0, 1'b0, "run_last_fall");
        enable = 1'b0;
      end
      wait_edge(1'b0, 1'b1, "run_rise");
      if (k == 1) begin
        check("run_first_valid", {31'd0, sample_valid}, 32'd0);
      end else begin
        check("run_valid", {31'd0, sample_valid}, 32'd1);
        check("run_data",  {24'd0, out_ad_data},  {24'd0, exp_q.pop_front()});
      end
    end
    repeat (10) @(negedge CLK_50M);
    check("run_valid_count", valid_count - snap, 32'd99);
    check("run_period",      period,             32'd40);
    check("run_busy_end",    {31'd0, busy},      32'd0);
    check("strobe_align",    strobe_misalign,    32'd0);
    check("data_stable",     data_change_errs,   32'd0);
    check("clk_low_cs_hi",   sclk_hi_errs,       32'd0);
    check("rise_interval_all", bad_interval,     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
